// File: rtl/cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module   : cp0_regfile
// Purpose  : MIPS Coprocessor-0 register file. Holds BadVAddr, Count, Compare,
//            Status, Cause and EPC. Serves mfc0 reads from ID and mtc0 writes
//            from WB, records exceptions, services eret and raises the
//            interrupt request.
// Options  : define CP0_TIMER_INT_EN to enable the Count==Compare timer
//            interrupt (Cause.TI, ORed into Cause.IP[7]).
// Revision : 1.0 - initial release
// ============================================================================
module cp0_regfile #(
    parameter logic [31:0] EXC_VECTOR     = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST     = 32'h0000_0000,
    parameter int          COUNT_DIV_LOG2 = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  read_addr,
    output logic [31:0] cp_read_data,
    input  logic        write_en,
    input  logic [4:0]  write_addr,
    input  logic [31:0] write_data,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_delayslot,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic [5:0]  int_hw,
    output logic        int_pending,
    output logic [31:0] exc_target,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o
);

    localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
    localparam logic [4:0]  ADDR_COUNT    = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
    localparam logic [4:0]  ADDR_STATUS   = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
    localparam logic [4:0]  ADDR_EPC      = 5'd14;
    localparam logic [31:0] STATUS_MASK   = 32'h0000_FF03;

    // Architectural state
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] epc;
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exc;
    logic        timer_int;

    // Derived values
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic        tick;
    logic        count_upd;
    logic [31:0] count_next;
    logic [7:0]  cause_ip;
    logic [31:0] status_val;
    logic [31:0] cause_val;
    logic        bypass;

    assign wr_count   = write_en && (write_addr == ADDR_COUNT);
    assign wr_compare = write_en && (write_addr == ADDR_COMPARE);
    assign wr_status  = write_en && (write_addr == ADDR_STATUS);
    assign wr_cause   = write_en && (write_addr == ADDR_CAUSE);
    assign wr_epc     = write_en && (write_addr == ADDR_EPC);

    assign cause_ip   = {cause_ip_hw[5] | timer_int, cause_ip_hw[4:0], cause_ip_sw};
    assign status_val = {16'h0000, status_im, 6'b000000, status_exl, status_ie};
    assign cause_val  = {cause_bd, timer_int, 14'h0000, cause_ip, 1'b0, cause_exc, 2'b00};

    // Count prescaler: Count advances when the divider wraps back to zero
    generate
        if (COUNT_DIV_LOG2 > 0) begin : g_prescaler
            logic [COUNT_DIV_LOG2-1:0] prescaler;
            // Free-running divider; an mtc0 to Count restarts a full period
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    prescaler <= '0;
                else if (wr_count)
                    prescaler <= '0;
                else
                    prescaler <= prescaler + COUNT_DIV_LOG2'(1);
            end
            assign tick = &prescaler;
        end else begin : g_no_prescaler
            assign tick = 1'b1;
        end
    endgenerate

    // Next Count value: an mtc0 overrides the tick for that cycle
    always_comb begin
        count_next = count;
        if (wr_count)
            count_next = write_data;
        else if (tick)
            count_next = count + 32'd1;
    end

    assign count_upd = wr_count | tick;

    // Count and Compare registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 32'h0;
            compare <= 32'h0;
        end else begin
            count <= count_next;
            if (wr_compare)
                compare <= write_data;
        end
    end

`ifdef CP0_TIMER_INT_EN
    // Timer interrupt: set when updated Count equals Compare, cleared only by writing Compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer_int <= 1'b0;
        else if (wr_compare)
            timer_int <= 1'b0;
        else if (count_upd && (count_next == compare))
            timer_int <= 1'b1;
    end
`else
    assign timer_int = 1'b0;
`endif

    // Status: mtc0 fields first, then eret/exception override EXL only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_im  <= STATUS_RST[15:8];
            status_exl <= STATUS_RST[1];
            status_ie  <= STATUS_RST[0];
        end else begin
            if (wr_status) begin
                status_im  <= write_data[15:8];
                status_exl <= write_data[1];
                status_ie  <= write_data[0];
            end
            if (exc_valid)
                status_exl <= 1'b1;
            else if (eret)
                status_exl <= 1'b0;
        end
    end

    // Cause: hardware IP sampled every cycle, software IP by mtc0, BD/ExcCode by exceptions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_bd    <= 1'b0;
            cause_ip_hw <= 6'h00;
            cause_ip_sw <= 2'b00;
            cause_exc   <= 5'h00;
        end else begin
            cause_ip_hw <= int_hw;
            if (wr_cause)
                cause_ip_sw <= write_data[9:8];
            if (exc_valid) begin
                cause_exc <= exc_code;
                if (!status_exl)
                    cause_bd <= exc_delayslot;
            end
        end
    end

    // EPC: nested exceptions (EXL already set) keep the original return address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc <= 32'h0;
        end else begin
            if (wr_epc)
                epc <= write_data;
            if (exc_valid && !status_exl)
                epc <= exc_delayslot ? (exc_pc - 32'd4) : exc_pc;
        end
    end

    // BadVAddr: captured only for address-error exceptions (codes 4 and 5)
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            badvaddr <= 32'h0;
        else if (exc_valid && ((exc_code == 5'd4) || (exc_code == 5'd5)))
            badvaddr <= exc_badvaddr;
    end

    // mfc0 read mux with same-cycle mtc0 bypass through the writable-bit masks
    always_comb begin
        bypass       = write_en && (write_addr == read_addr);
        cp_read_data = 32'h0;
        case (read_addr)
            ADDR_BADVADDR: cp_read_data = badvaddr;
            ADDR_COUNT:    cp_read_data = bypass ? write_data : count;
            ADDR_COMPARE:  cp_read_data = bypass ? write_data : compare;
            ADDR_STATUS:   cp_read_data = bypass ? (write_data & STATUS_MASK) : status_val;
            ADDR_CAUSE:    cp_read_data = bypass ? {cause_val[31:10], write_data[9:8], cause_val[7:0]}
                                                 : cause_val;
            ADDR_EPC:      cp_read_data = bypass ? write_data : epc;
            default:       cp_read_data = 32'h0;
        endcase
    end

    assign int_pending = status_ie & ~status_exl & (|(cause_ip & status_im));
    assign exc_target  = eret ? epc : EXC_VECTOR;
    assign status_o    = status_val;
    assign cause_o     = cause_val;
    assign epc_o       = epc;

endmodule
`default_nettype wire
